// File: rtl/sar_capture.sv
// ---------------------------------------------------------------------------
// sar_capture
//
// Receives conversion results from the asynchronously clocked SAR logic and
// brings them into the system clock domain. The conversion-complete flag
// `compl` is synchronized and its falling edge triggers a capture of
// `adc_data`, which the SAR holds stable for a whole conversion after that
// edge. Captured words are queued in a small first-word fall-through FIFO and
// presented to the back end as a valid/ready stream. A result that arrives
// while the FIFO is full and not being popped is dropped and counted.
//
// Build option:
//   SAR_CAPTURE_TWOS_EN  when defined, the stored word is two's complement
//                        (MSB inverted on capture); otherwise it is straight
//                        offset binary as delivered by the SAR.
//
// Parameters:
//   ADC_BITS     result width (must match the SAR logic)
//   FIFO_DEPTH   FIFO entries, power of two, >= 2
//   SYNC_STAGES  flops in the compl synchronizer, >= 2
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   adc_data    SAR result, bit 0 is the MSB (first decided bit)
//   compl       SAR conversion-complete flag, asynchronous to clk
//   dout        head-of-FIFO word, dout[ADC_BITS-1] is the MSB
//   dout_valid  FIFO non-empty
//   dout_ready  consumer accepts dout this cycle
//   overflow    sticky, a result was dropped because the FIFO was full
//   drop_cnt    number of dropped results, saturates at 255
//   clr_ovf     synchronous clear of overflow and drop_cnt
// ---------------------------------------------------------------------------
module sar_capture #(
    parameter int unsigned ADC_BITS    = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [0:ADC_BITS-1] adc_data,
    input  logic                compl,
    output logic [ADC_BITS-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                overflow,
    output logic [7:0]          drop_cnt,
    input  logic                clr_ovf
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    // ------------------------------------------------------------------
    // compl synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   compl_s;
    logic                   compl_d;
    logic                   cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            compl_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], compl};
            compl_d <= compl_s;
        end
    end

    assign compl_s = sync_q[SYNC_STAGES-1];
    // The SAR updates adc_data as compl falls, so the falling edge marks a
    // stable result; a compl still high after reset only looks like a rise.
    assign cap     = compl_d & ~compl_s;

    // ------------------------------------------------------------------
    // Capture word: reverse bit order so the first decided bit is the MSB
    // ------------------------------------------------------------------
    logic [ADC_BITS-1:0] cap_word;

    always_comb begin
        cap_word = '0;
        for (int unsigned k = 0; k < ADC_BITS; k++) begin
            cap_word[ADC_BITS-1-k] = adc_data[k];
        end
`ifdef SAR_CAPTURE_TWOS_EN
        cap_word[ADC_BITS-1] = ~cap_word[ADC_BITS-1];
`endif
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [ADC_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr_n;
    logic [PW-1:0]       rd_ptr_n;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;
    logic                empty_n;
    logic [ADC_BITS-1:0] head_n;

    assign full = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign pop  = dout_valid & dout_ready;
    // A full FIFO still accepts the push when the head leaves on this edge.
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    assign wr_ptr_n = wr_ptr + PW'(push);
    assign rd_ptr_n = rd_ptr + PW'(pop);
    assign empty_n  = (wr_ptr_n == rd_ptr_n);

    // dout is registered, so the next head is resolved here: if the new head
    // slot is the one being written on this edge, bypass the incoming word.
    always_comb begin
        head_n = mem[rd_ptr_n[AW-1:0]];
        if (push && (rd_ptr_n == wr_ptr)) begin
            head_n = cap_word;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cap_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            dout_valid <= ~empty_n;
            if (!empty_n) begin
                dout <= head_n;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop accounting; a drop in the same cycle as a clear wins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sar_capture.sv
// ---------------------------------------------------------------------------
// tb_sar_capture
//
// Directed self-checking bench for sar_capture with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge, away from
// the active rising edge. Expected words are written as offset-binary values
// and adjusted for the SAR_CAPTURE_TWOS_EN build through MSB_FLIP.
// ---------------------------------------------------------------------------
module tb_sar_capture;

`ifdef SAR_CAPTURE_TWOS_EN
    localparam logic [7:0] MSB_FLIP = 8'h80;
`else
    localparam logic [7:0] MSB_FLIP = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [0:7] adc_data;
    logic       compl;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_ovf;

    int checks   = 0;
    int failures = 0;

    sar_capture #(
        .ADC_BITS    (8),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_data   (adc_data),
        .compl      (compl),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // compl high for 5 clocks, then falls with the new result; returns after
    // the push edge (3 edges after the fall) with compl still low.
    task automatic convert(input logic [0:7] v);
        compl = 1'b1;
        cyc(5);
        adc_data = v;
        compl    = 1'b0;
        cyc(3);
    endtask

    // Pops n words back to back, expecting first, first+1, ... then empty.
    task automatic drain(input logic [7:0] first, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
            chk({tag, "_data"}, 32'(dout), 32'((first + 8'(i)) ^ MSB_FLIP));
            dout_ready = 1'b1;
            cyc(1);
        end
        chk({tag, "_empty"}, 32'(dout_valid), 32'd0);
        dout_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        adc_data   = '0;
        compl      = 1'b0;
        dout_ready = 1'b0;
        clr_ovf    = 1'b0;
        cyc(2);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Single conversion: latency of three edges, then popped immediately
        dout_ready = 1'b1;
        adc_data   = 8'b10100101;
        compl      = 1'b1;
        cyc(5);
        compl = 1'b0;
        cyc(1);
        chk("lat_e0", 32'(dout_valid), 32'd0);
        cyc(1);
        chk("lat_e1", 32'(dout_valid), 32'd0);
        cyc(1);
        chk("lat_e2_valid", 32'(dout_valid), 32'd1);
        chk("lat_e2_data", 32'(dout), 32'(8'hA5 ^ MSB_FLIP));
        cyc(1);
        chk("pop_valid", 32'(dout_valid), 32'd0);
        chk("pop_hold", 32'(dout), 32'(8'hA5 ^ MSB_FLIP));
        dout_ready = 1'b0;

        // Bit order
        adc_data    = '0;
        adc_data[0] = 1'b1;
        convert(adc_data);
        chk("bit0_valid", 32'(dout_valid), 32'd1);
        chk("bit0_data", 32'(dout), 32'(8'h80 ^ MSB_FLIP));
        dout_ready = 1'b1;
        cyc(1);
        dout_ready = 1'b0;
        chk("bit0_popped", 32'(dout_valid), 32'd0);
        adc_data    = '0;
        adc_data[7] = 1'b1;
        convert(adc_data);
        chk("bit7_data", 32'(dout), 32'(8'h01 ^ MSB_FLIP));
        dout_ready = 1'b1;
        cyc(1);
        dout_ready = 1'b0;
        chk("bit7_popped", 32'(dout_valid), 32'd0);

        // Overflow: five results into a four-entry FIFO
        for (int i = 1; i <= 4; i++) convert(8'(i));
        chk("fill_ovf", 32'(overflow), 32'd0);
        chk("fill_drop", 32'(drop_cnt), 32'd0);
        convert(8'h05);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd1);
        drain(8'h01, 4, "ovf_drain");

        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("clr1_ovf", 32'(overflow), 32'd0);
        chk("clr1_drop", 32'(drop_cnt), 32'd0);

        // Full FIFO with pop on the capture edge: nothing is dropped
        for (int i = 0; i < 4; i++) convert(8'h11 + 8'(i));
        compl = 1'b1;
        cyc(5);
        adc_data = 8'h15;
        compl    = 1'b0;
        cyc(2);
        dout_ready = 1'b1;
        cyc(1);
        dout_ready = 1'b0;
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_drop", 32'(drop_cnt), 32'd0);
        drain(8'h12, 4, "pp_drain");

        // Clear priority
        for (int i = 0; i < 7; i++) convert(8'h21 + 8'(i));
        chk("drop3_ovf", 32'(overflow), 32'd1);
        chk("drop3_cnt", 32'(drop_cnt), 32'd3);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("clr3_ovf", 32'(overflow), 32'd0);
        chk("clr3_cnt", 32'(drop_cnt), 32'd0);
        compl = 1'b1;
        cyc(5);
        adc_data = 8'h28;
        compl    = 1'b0;
        cyc(2);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("clrdrop_ovf", 32'(overflow), 32'd1);
        chk("clrdrop_cnt", 32'(drop_cnt), 32'd1);

        // Saturation of drop_cnt; FIFO contents untouched
        repeat (260) convert(8'h30);
        chk("sat_cnt", 32'(drop_cnt), 32'hFF);
        chk("sat_head", 32'(dout), 32'(8'h21 ^ MSB_FLIP));
        drain(8'h21, 4, "sat_drain");

        // Asynchronous reset between clock edges with two entries queued
        convert(8'h31);
        convert(8'h32);
        chk("q2_valid", 32'(dout_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        #1 rst = 1'b0;
        cyc(1);
        convert(8'h41);
        chk("post_valid", 32'(dout_valid), 32'd1);
        chk("post_data", 32'(dout), 32'(8'h41 ^ MSB_FLIP));
        dout_ready = 1'b1;
        cyc(1);
        dout_ready = 1'b0;
        chk("post_one", 32'(dout_valid), 32'd0);
        cyc(5);
        chk("post_none", 32'(dout_valid), 32'd0);

        // compl held high across reset: no capture until it falls
        compl = 1'b1;
        cyc(5);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        cyc(5);
        chk("hi_rst_nocap", 32'(dout_valid), 32'd0);
        adc_data = 8'h55;
        compl    = 1'b0;
        cyc(3);
        chk("hi_rst_valid", 32'(dout_valid), 32'd1);
        chk("hi_rst_data", 32'(dout), 32'(8'h55 ^ MSB_FLIP));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
